// File: rtl/elc3_pkg.sv
// elc3_pkg: shared types and constants for the elc3 memory/MMIO controller.
//   mem_state_t : controller FSM states
//   MMIO_BASE   : first address of the memory-mapped register window
//   ADDR_SW     : board switch register (read-only)
//   ADDR_HEX    : hex display register (read/write)
package elc3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } mem_state_t;

    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_SW   = 16'hFFFF;
    localparam logic [15:0] ADDR_HEX  = 16'hFFFE;

    function automatic logic is_mmio(input logic [15:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/elc3_mmio_regs.sv
// elc3_mmio_regs: address decode and storage for the memory-mapped registers.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : one-cycle write strobe for an MMIO write access
//   addr      : MMIO address (only meaningful inside the MMIO window)
//   wdata     : write data
//   sw        : board switches
//   rdata     : combinational read data for addr
//   hex_data  : display register
module elc3_mmio_regs
    import elc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [17:0] sw,
    output logic [15:0] rdata,
    output logic [15:0] hex_data
);

    logic [15:0] hex_q;
    // The two top switches have no register mapping.
    logic        unused_sw;

    assign unused_sw = ^sw[17:16];
    assign hex_data  = hex_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hex_q <= '0;
        else if (wr_en && addr == ADDR_HEX)
            hex_q <= wdata;
    end

    always_comb begin
        rdata = '0;
        if (addr == ADDR_SW)
            rdata = sw[15:0];
        else if (addr == ADDR_HEX)
            rdata = hex_q;
    end

endmodule

// File: rtl/elc3_mem_ctrl.sv
// elc3_mem_ctrl: turns the CPU's level-held MIO_EN/R_W request into DE2
// async-SRAM strobe sequences, services MMIO registers, and returns read
// data with a one-cycle ready pulse R.
//   RD_WAIT / WR_PULSE : cycles OE_N/CE_N low before sampling / WE_N low
//   Clk, Reset         : clock, asynchronous active-high reset
//   MIO_EN, R_W        : request (held until R), 1 = write
//   Addr, Data_In      : MAR / MDR values, latched on acceptance
//   SW                 : board switches
//   Data_Out, R        : read data (held until next read), ready pulse
//   Hex_Data           : display register
//   SRAM_*             : SRAM address, data bus and active-low strobes
module elc3_mem_ctrl
    import elc3_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] Addr,
    input  logic [15:0] Data_In,
    input  logic [17:0] SW,
    output logic [15:0] Data_Out,
    output logic        R,
    output logic [15:0] Hex_Data,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    mem_state_t  state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [15:0] data_out_q;
    logic [15:0] mmio_rdata;
    logic        accept;
    logic        mmio_acc;
    logic        ce_n, oe_n, we_n, dq_oe, ready;

    // Only IDLE accepts; DONE always falls back to IDLE first, so a request
    // still held across DONE cannot start a second access.
    assign accept   = (state_q == ST_IDLE) && MIO_EN;
    assign mmio_acc = accept && is_mmio(Addr);

    // MMIO decode uses the live address: the access completes at the
    // accepting edge itself.
    elc3_mmio_regs u_mmio (
        .clk      (Clk),
        .rst      (Reset),
        .wr_en    (mmio_acc && R_W),
        .addr     (Addr),
        .wdata    (Data_In),
        .sw       (SW),
        .rdata    (mmio_rdata),
        .hex_data (Hex_Data)
    );

    // R_W is consumed at acceptance by choosing the READ or write path, so
    // the state itself is the latched copy.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            data_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MIO_EN) begin
                        addr_q <= Addr;
                        data_q <= Data_In;
                        if (is_mmio(Addr)) begin
                            if (!R_W)
                                data_out_q <= mmio_rdata;
                            state_q <= ST_DONE;
                        end else if (R_W) begin
                            state_q <= ST_WR_SETUP;
                        end else begin
                            cnt_q   <= CW'(RD_WAIT - 1);
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (cnt_q == '0) begin
                        data_out_q <= SRAM_DQ;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_WR_SETUP: begin
                    cnt_q   <= CW'(WR_PULSE - 1);
                    state_q <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (cnt_q == '0)
                        state_q <= ST_WR_HOLD;
                    else
                        cnt_q <= cnt_q - CW'(1);
                end
                ST_WR_HOLD: state_q <= ST_DONE;
                ST_DONE:    state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes, R and the bus enable come from the state register alone so
    // they cannot glitch; reset forces IDLE and thus deasserts them at once.
    always_comb begin
        ce_n  = 1'b1;
        oe_n  = 1'b1;
        we_n  = 1'b1;
        dq_oe = 1'b0;
        ready = 1'b0;
        case (state_q)
            ST_READ: begin
                ce_n = 1'b0;
                oe_n = 1'b0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n  = 1'b0;
                dq_oe = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n  = 1'b0;
                we_n  = 1'b0;
                dq_oe = 1'b1;
            end
            ST_DONE: ready = 1'b1;
            default: ;
        endcase
    end

    assign SRAM_ADDR = {4'h0, addr_q};
    assign SRAM_DQ   = dq_oe ? data_q : 'z;
    assign SRAM_CE_N = ce_n;
    assign SRAM_OE_N = oe_n;
    assign SRAM_WE_N = we_n;
    assign SRAM_LB_N = ce_n;
    assign SRAM_UB_N = ce_n;
    assign R         = ready;
    assign Data_Out  = data_out_q;

endmodule

// File: tb/tb_elc3_mem_ctrl.sv
module tb_elc3_mem_ctrl;

    localparam int NREC = 9;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] Addr;
    logic [15:0] Data_In;
    logic [17:0] SW;
    logic [15:0] Data_Out;
    logic        R;
    logic [15:0] Hex_Data;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] sram_dq;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    elc3_mem_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MIO_EN    (MIO_EN),
        .R_W       (R_W),
        .Addr      (Addr),
        .Data_In   (Data_In),
        .SW        (SW),
        .Data_Out  (Data_Out),
        .R         (R),
        .Hex_Data  (Hex_Data),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_UB_N (SRAM_UB_N)
    );

    always #5 Clk = ~Clk;

    // SRAM model: 256 words indexed by address nibbles {15:12, 3:0}.
    logic [15:0] mem [0:255];
    logic [7:0]  midx;
    assign midx    = {SRAM_ADDR[15:12], SRAM_ADDR[3:0]};
    assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[midx] : 'z;
    always @(posedge SRAM_WE_N) if (SRAM_CE_N == 1'b0) mem[midx] = sram_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // OE_N and WE_N must never be low together.
    always @(negedge Clk) if (mon_en) chk("oe_we_overlap", 32'(SRAM_OE_N | SRAM_WE_N), 32'd1);

    // Per-cycle record of one access; cycle k is the period ending at edge k
    // after the accepting edge (accepting edge ends cycle 0).
    logic        rec_r [1:NREC], rec_we [1:NREC], rec_oe [1:NREC], rec_ce [1:NREC];
    logic [15:0] rec_dq [1:NREC];
    logic [19:0] rec_addr [1:NREC];
    int rfirst, npulse, n_we, n_oe, n_ce;

    task automatic access(input logic rw, input logic [15:0] a, input logic [15:0] d,
                          input logic [17:0] sw, input int drop_k, input bit hold);
        int hold_until;
        hold_until = -1;
        @(negedge Clk);
        SW = sw; MIO_EN = 1'b1; R_W = rw; Addr = a; Data_In = d;
        for (int k = 1; k <= NREC; k++) begin
            @(negedge Clk);
            rec_r[k] = R; rec_we[k] = SRAM_WE_N; rec_oe[k] = SRAM_OE_N;
            rec_ce[k] = SRAM_CE_N; rec_dq[k] = sram_dq; rec_addr[k] = SRAM_ADDR;
            if (k == 1) begin Addr = ~a; Data_In = ~d; R_W = ~rw; end
            if (k == drop_k) MIO_EN = 1'b0;
            if (k == hold_until) MIO_EN = 1'b0;
            if (R) begin
                if (hold) hold_until = k + 1;
                else MIO_EN = 1'b0;
            end
        end
        MIO_EN = 1'b0;
        rfirst = 0; npulse = 0; n_we = 0; n_oe = 0; n_ce = 0;
        for (int k = 1; k <= NREC; k++) begin
            if (rec_r[k]) begin npulse++; if (rfirst == 0) rfirst = k; end
            if (!rec_we[k]) n_we++;
            if (!rec_oe[k]) n_oe++;
            if (!rec_ce[k]) n_ce++;
        end
    endtask

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [17:0] sw;
        int          rcyc;
        logic        chk_d;
        logic [15:0] exp_d;
        logic [15:0] exp_hex;
        logic        sram;
    } vec_t;

    vec_t tbl [11];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        tbl[0]  = '{1'b1, 16'h0042, 16'hA5A5, 18'h0,     5, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[1]  = '{1'b0, 16'h0042, 16'h0000, 18'h0,     3, 1'b1, 16'hA5A5, 16'h0000, 1'b1};
        tbl[2]  = '{1'b1, 16'hFFFE, 16'h1234, 18'h0,     1, 1'b0, 16'h0000, 16'h1234, 1'b0};
        tbl[3]  = '{1'b0, 16'hFFFF, 16'h0000, 18'h00030, 1, 1'b1, 16'h0030, 16'h1234, 1'b0};
        tbl[4]  = '{1'b0, 16'hFE10, 16'h0000, 18'h00030, 1, 1'b1, 16'h0000, 16'h1234, 1'b0};
        tbl[5]  = '{1'b0, 16'hFFFE, 16'h0000, 18'h0,     1, 1'b1, 16'h1234, 16'h1234, 1'b0};
        tbl[6]  = '{1'b1, 16'hFFFF, 16'h5555, 18'h0,     1, 1'b0, 16'h0000, 16'h1234, 1'b0};
        tbl[7]  = '{1'b0, 16'hFFFF, 16'h0000, 18'h3ABCD, 1, 1'b1, 16'hABCD, 16'h1234, 1'b0};
        tbl[8]  = '{1'b1, 16'hFE00, 16'h9999, 18'h0,     1, 1'b0, 16'h0000, 16'h1234, 1'b0};
        tbl[9]  = '{1'b0, 16'hFDFF, 16'h0000, 18'h0,     3, 1'b1, 16'h0000, 16'h1234, 1'b1};
        tbl[10] = '{1'b1, 16'hFFFE, 16'h00C3, 18'h0,     1, 1'b0, 16'h0000, 16'h00C3, 1'b0};

        Reset = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; Addr = '0; Data_In = '0; SW = '0;
        #1;
        chk("rst_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1F);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_hex", 32'(Hex_Data), 32'd0);
        chk("rst_dout", 32'(Data_Out), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_dq_z", 32'((sram_dq === 16'hzzzz) || (sram_dq === 16'h0000)), 32'd1);
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk);
        chk("idle_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1F);
        chk("idle_r", 32'(R), 32'd0);
        mon_en = 1'b1;

        // SRAM write, detailed strobe timing
        access(1'b1, 16'h3000, 16'hBEEF, 18'h0, 0, 1'b0);
        chk("wr_r_cycle", 32'(rfirst), 32'd5);
        chk("wr_r_pulses", 32'(npulse), 32'd1);
        chk("wr_we_count", 32'(n_we), 32'd2);
        chk("wr_we_window", {30'd0, rec_we[2], rec_we[3]}, 32'd0);
        chk("wr_oe_count", 32'(n_oe), 32'd0);
        chk("wr_sram_addr", 32'(rec_addr[1]), 32'h03000);
        for (int k = 1; k <= 4; k++) chk("wr_dq", 32'(rec_dq[k]), 32'hBEEF);
        chk("wr_mem", 32'(mem[8'h30]), 32'hBEEF);

        // SRAM read back
        access(1'b0, 16'h3000, 16'h0000, 18'h0, 0, 1'b0);
        chk("rd_r_cycle", 32'(rfirst), 32'd3);
        chk("rd_r_pulses", 32'(npulse), 32'd1);
        chk("rd_oe_count", 32'(n_oe), 32'd2);
        chk("rd_oe_window", {30'd0, rec_oe[1], rec_oe[2]}, 32'd0);
        chk("rd_we_count", 32'(n_we), 32'd0);
        chk("rd_data", 32'(Data_Out), 32'hBEEF);

        // table of SRAM and MMIO accesses
        foreach (tbl[i]) begin
            access(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].sw, 0, 1'b0);
            chk($sformatf("v%0d_r_cycle", i), 32'(rfirst), 32'(tbl[i].rcyc));
            chk($sformatf("v%0d_r_pulses", i), 32'(npulse), 32'd1);
            if (tbl[i].chk_d) chk($sformatf("v%0d_data", i), 32'(Data_Out), 32'(tbl[i].exp_d));
            chk($sformatf("v%0d_hex", i), 32'(Hex_Data), 32'(tbl[i].exp_hex));
            if (!tbl[i].sram) chk($sformatf("v%0d_no_sram", i), 32'(n_ce), 32'd0);
        end

        // MIO_EN dropped one cycle after acceptance
        access(1'b0, 16'h3000, 16'h0000, 18'h0, 1, 1'b0);
        chk("drop_r_cycle", 32'(rfirst), 32'd3);
        chk("drop_r_pulses", 32'(npulse), 32'd1);
        chk("drop_data", 32'(Data_Out), 32'hBEEF);

        // MIO_EN held across DONE
        access(1'b0, 16'h0042, 16'h0000, 18'h0, 0, 1'b1);
        chk("hold_r_cycle", 32'(rfirst), 32'd3);
        chk("hold_r_pulses", 32'(npulse), 32'd1);
        chk("hold_idle_ce", 32'(rec_ce[4]), 32'd1);
        chk("hold_ce_count", 32'(n_ce), 32'd2);

        // reset during WR_PULSE
        @(negedge Clk);
        MIO_EN = 1'b1; R_W = 1'b1; Addr = 16'h4000; Data_In = 16'h1111;
        @(negedge Clk);
        @(negedge Clk);
        chk("rstw_in_pulse", 32'(SRAM_WE_N), 32'd0);
        Reset = 1'b1;
        #1;
        chk("rstw_we", 32'(SRAM_WE_N), 32'd1);
        chk("rstw_ce", 32'(SRAM_CE_N), 32'd1);
        chk("rstw_r", 32'(R), 32'd0);
        MIO_EN = 1'b0;
        @(negedge Clk); Reset = 1'b0;
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (R) npulse++;
        end
        chk("rstw_no_r", 32'(npulse), 32'd0);
        chk("rstw_hex", 32'(Hex_Data), 32'd0);
        access(1'b0, 16'h3000, 16'h0000, 18'h0, 0, 1'b0);
        chk("post_rst_r_cycle", 32'(rfirst), 32'd3);
        chk("post_rst_data", 32'(Data_Out), 32'hBEEF);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
